// File: rtl/hidden_mailbox_pkg.sv
// Shared constants and message type for hidden_mailbox.
// Default widths apply when the top-level parameters are not overridden.
package hidden_mailbox_pkg;

   localparam int unsigned DEF_ADDR_W = 64;
   localparam int unsigned DEF_DATA_W = 32;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
   } msg_t;

endpackage

// File: rtl/hidden_mailbox_fifo.sv
// Single-channel queue for hidden_mailbox: power-of-2 depth, wrapping pointers,
// first-word head output. clr empties the queue synchronously, like rst.
module hidden_mailbox_fifo
   import hidden_mailbox_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = $bits(msg_t)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
      mem_q <= mem_d;
   end

   assign full  = (cnt_q == CNT_W'(DEPTH));
   assign empty = (cnt_q == '0);
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/hidden_mailbox.sv
// Multi-channel mailbox: per-channel FIFOs, round-robin merge into one registered output.
// Optional statistics ports are enabled by defining HIDDEN_MAILBOX_STATS_EN.
module hidden_mailbox
   import hidden_mailbox_pkg::*;
#(
   parameter int unsigned  NUM_CH = 4,
   parameter int unsigned  DEPTH  = 4,
   parameter int unsigned  ADDR_W = DEF_ADDR_W,
   parameter int unsigned  DATA_W = DEF_DATA_W,
   localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [NUM_CH-1:0]        wr_valid,
   output logic [NUM_CH-1:0]        wr_ready,
   input  logic [NUM_CH*ADDR_W-1:0] wr_addr,
   input  logic [NUM_CH*DATA_W-1:0] wr_data,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [ADDR_W-1:0]        rd_addr,
   output logic [DATA_W-1:0]        rd_data,
   output logic [CH_W-1:0]          rd_ch
`ifdef HIDDEN_MAILBOX_STATS_EN
   ,
   output logic [31:0]              stat_delivered,
   output logic [NUM_CH-1:0]        stat_stall
`endif
);

   localparam int unsigned MSG_W = ADDR_W + DATA_W;

   logic [NUM_CH-1:0] push, pop, full, empty;
   logic [MSG_W-1:0]  head [NUM_CH];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      hidden_mailbox_fifo #(
         .DEPTH (DEPTH),
         .W     (MSG_W)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .clr   (flush),
         .push  (push[c]),
         .pop   (pop[c]),
         .din   ({wr_addr[c*ADDR_W +: ADDR_W], wr_data[c*DATA_W +: DATA_W]}),
         .full  (full[c]),
         .empty (empty[c]),
         .head  (head[c])
      );
   end

   logic              rd_valid_q, rd_valid_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [CH_W-1:0]   rd_ch_q, rd_ch_d;
   logic [CH_W-1:0]   prio_q, prio_d;
   logic [CH_W-1:0]   cand, gnt_ch;
   logic              gnt_vld;
   logic              load_en;

   assign wr_ready = ~full;
   assign push     = wr_valid & ~full & {NUM_CH{~flush}};
   assign load_en  = ~rd_valid_q | rd_ready;

   // First non-empty channel scanning upward from prio_q, wrapping at NUM_CH.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_ch  = '0;
      cand    = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         cand = CH_W'((32'(prio_q) + i) % NUM_CH);
         if (!gnt_vld && !empty[cand]) begin
            gnt_vld = 1'b1;
            gnt_ch  = cand;
         end
      end
   end

   always_comb begin
      rd_valid_d = rd_valid_q;
      rd_addr_d  = rd_addr_q;
      rd_data_d  = rd_data_q;
      rd_ch_d    = rd_ch_q;
      prio_d     = prio_q;
      pop        = '0;
      if (flush) begin
         rd_valid_d = 1'b0;
         prio_d     = '0;
      end else if (load_en) begin
         rd_valid_d = gnt_vld;
         if (gnt_vld) begin
            pop[gnt_ch]            = 1'b1;
            {rd_addr_d, rd_data_d} = head[gnt_ch];
            rd_ch_d                = gnt_ch;
            prio_d                 = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_addr_q  <= '0;
         rd_data_q  <= '0;
         rd_ch_q    <= '0;
         prio_q     <= '0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_addr_q  <= rd_addr_d;
         rd_data_q  <= rd_data_d;
         rd_ch_q    <= rd_ch_d;
         prio_q     <= prio_d;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_addr  = rd_addr_q;
   assign rd_data  = rd_data_q;
   assign rd_ch    = rd_ch_q;

`ifdef HIDDEN_MAILBOX_STATS_EN
   logic [31:0]       stat_delivered_q, stat_delivered_d;
   logic [NUM_CH-1:0] stat_stall_q, stat_stall_d;

   // Statistics survive flush; only rst clears them.
   always_comb begin
      stat_delivered_d = stat_delivered_q + 32'(rd_valid_q && rd_ready);
      stat_stall_d     = stat_stall_q | (wr_valid & full);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_delivered_q <= '0;
         stat_stall_q     <= '0;
      end else begin
         stat_delivered_q <= stat_delivered_d;
         stat_stall_q     <= stat_stall_d;
      end
   end

   assign stat_delivered = stat_delivered_q;
   assign stat_stall     = stat_stall_q;
`endif

endmodule

// File: tb/tb_hidden_mailbox.sv
// Testbench for hidden_mailbox: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_hidden_mailbox;
   import hidden_mailbox_pkg::*;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DATA_W = 32;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     flush;
   logic [NUM_CH-1:0]        wr_valid;
   logic [NUM_CH-1:0]        wr_ready;
   logic [NUM_CH*ADDR_W-1:0] wr_addr;
   logic [NUM_CH*DATA_W-1:0] wr_data;
   logic                     rd_valid;
   logic                     rd_ready;
   logic [ADDR_W-1:0]        rd_addr;
   logic [DATA_W-1:0]        rd_data;
   logic [1:0]               rd_ch;
`ifdef HIDDEN_MAILBOX_STATS_EN
   logic [31:0]              stat_delivered;
   logic [NUM_CH-1:0]        stat_stall;
`endif

   hidden_mailbox #(
      .NUM_CH (NUM_CH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .wr_valid       (wr_valid),
      .wr_ready       (wr_ready),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .rd_valid       (rd_valid),
      .rd_ready       (rd_ready),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .rd_ch          (rd_ch)
`ifdef HIDDEN_MAILBOX_STATS_EN
      ,
      .stat_delivered (stat_delivered),
      .stat_stall     (stat_stall)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one queue per channel plus the single output slot.
   msg_t              mq [NUM_CH][$];
   bit                m_valid = 1'b0;
   msg_t              m_msg   = '0;
   int                m_ch    = 0;
   int                m_prio  = 0;
   bit [31:0]         m_deliv = '0;
   bit [NUM_CH-1:0]   m_stall = '0;

   initial forever begin
      bit   acc [NUM_CH];
      int   k;
      int   c2;
      msg_t tmp;
      @(posedge clk);
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) mq[c].delete();
         m_valid = 1'b0;
         m_msg   = '0;
         m_ch    = 0;
         m_prio  = 0;
         m_deliv = '0;
         m_stall = '0;
      end else begin
         if (m_valid && rd_ready) m_deliv = m_deliv + 1;
         for (int c = 0; c < NUM_CH; c++)
            if (wr_valid[c] && mq[c].size() >= DEPTH) m_stall[c] = 1'b1;
         if (flush) begin
            for (int c = 0; c < NUM_CH; c++) mq[c].delete();
            m_valid = 1'b0;
            m_prio  = 0;
         end else begin
            for (int c = 0; c < NUM_CH; c++)
               acc[c] = wr_valid[c] && (mq[c].size() < DEPTH);
            if (!m_valid || rd_ready) begin
               k = -1;
               for (int i = 0; i < NUM_CH; i++) begin
                  c2 = (m_prio + i) % NUM_CH;
                  if (k < 0 && mq[c2].size() > 0) k = c2;
               end
               if (k >= 0) begin
                  m_msg   = mq[k].pop_front();
                  m_ch    = k;
                  m_prio  = (k + 1) % NUM_CH;
                  m_valid = 1'b1;
               end else begin
                  m_valid = 1'b0;
               end
            end
            for (int c = 0; c < NUM_CH; c++) begin
               if (acc[c]) begin
                  tmp.addr = wr_addr[c*ADDR_W +: ADDR_W];
                  tmp.data = wr_data[c*DATA_W +: DATA_W];
                  mq[c].push_back(tmp);
               end
            end
         end
      end
   end

   initial forever begin
      logic [NUM_CH-1:0] exp_rdy;
      @(negedge clk);
      if (chk_en) begin
         for (int c = 0; c < NUM_CH; c++) exp_rdy[c] = (mq[c].size() < DEPTH);
         chk("model_rd_valid", 128'(rd_valid), 128'(m_valid));
         chk("model_rd_addr",  128'(rd_addr),  128'(m_msg.addr));
         chk("model_rd_data",  128'(rd_data),  128'(m_msg.data));
         chk("model_rd_ch",    128'(rd_ch),    128'(m_ch));
         chk("model_wr_ready", 128'(wr_ready), 128'(exp_rdy));
`ifdef HIDDEN_MAILBOX_STATS_EN
         chk("model_stat_delivered", 128'(stat_delivered), 128'(m_deliv));
         chk("model_stat_stall",     128'(stat_stall),     128'(m_stall));
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wr(input int c, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wr_valid[c]                 = 1'b1;
      wr_addr[c*ADDR_W +: ADDR_W] = a;
      wr_data[c*DATA_W +: DATA_W] = d;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      flush    = 1'b0;
      wr_valid = '0;
      rd_ready = 1'b0;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int acc;
      int exp_ch [8];
      exp_ch = '{0, 1, 2, 3, 0, 1, 2, 3};
      wr_addr = '0;
      wr_data = '0;
      do_reset();
      chk_en = 1'b1;
      chk("reset_rd_valid", 128'(rd_valid), 128'(0));
      chk("reset_rd_addr",  128'(rd_addr),  128'(0));
      chk("reset_rd_ch",    128'(rd_ch),    128'(0));
      chk("reset_wr_ready", 128'(wr_ready), 128'(4'hF));

      // Single-message latency.
      rd_ready = 1'b1;
      set_wr(0, 64'h1000, 32'hA5A5A5A5);
      step();
      wr_valid = '0;
      chk("lat_edge1_valid", 128'(rd_valid), 128'(0));
      step();
      chk("lat_edge2_valid", 128'(rd_valid), 128'(1));
      chk("lat_edge2_ch",    128'(rd_ch),    128'(0));
      chk("lat_edge2_addr",  128'(rd_addr),  128'(64'h1000));
      chk("lat_edge2_data",  128'(rd_data),  128'(32'hA5A5A5A5));
      step();
      chk("lat_edge3_valid", 128'(rd_valid), 128'(0));

      // Fill ch2 under backpressure, then drain in order.
      do_reset();
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         set_wr(2, 64'hB000 + 64'(acc + 1), 32'(acc + 1));
         if (wr_ready[2]) acc++;
         step();
      end
      wr_valid = '0;
      chk("fill_accepts",  128'(acc),         128'(5));
      chk("fill_wr_ready", 128'(wr_ready[2]), 128'(0));
      rd_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         chk("drain_valid", 128'(rd_valid), 128'(1));
         chk("drain_data",  128'(rd_data),  128'(i));
         step();
      end
      chk("drain_empty", 128'(rd_valid), 128'(0));

      // Round-robin across four loaded channels.
      do_reset();
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < NUM_CH; c++) set_wr(c, 64'(16'hC00 + c*16 + k), 32'(c*16 + k));
         step();
      end
      wr_valid = '0;
      rd_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("rr_valid", 128'(rd_valid), 128'(1));
         chk("rr_ch",    128'(rd_ch),    128'(exp_ch[i]));
         step();
      end
      chk("rr_done", 128'(rd_valid), 128'(0));

      // Flush with a held output and a simultaneous ch1 write.
      do_reset();
      set_wr(0, 64'hD0, 32'hD0);
      step();
      wr_valid = '0;
      step();
      chk("flush_held", 128'(rd_valid), 128'(1));
      flush = 1'b1;
      set_wr(1, 64'hD1, 32'hD1);
      step();
      flush    = 1'b0;
      wr_valid = '0;
      chk("flush_valid",    128'(rd_valid), 128'(0));
      chk("flush_wr_ready", 128'(wr_ready), 128'(4'hF));
      rd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("flush_no_deliver", 128'(rd_valid), 128'(0));
      end

      // Reset while an output is held.
      do_reset();
      set_wr(1, 64'hE1E1, 32'hE1);
      step();
      wr_valid = '0;
      step();
      chk("rst_held", 128'(rd_valid), 128'(1));
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_mid_valid", 128'(rd_valid), 128'(0));
      chk("rst_mid_addr",  128'(rd_addr),  128'(0));
      chk("rst_mid_data",  128'(rd_data),  128'(0));
      chk("rst_mid_ch",    128'(rd_ch),    128'(0));
`ifdef HIDDEN_MAILBOX_STATS_EN
      chk("rst_mid_delivered", 128'(stat_delivered), 128'(0));

      do_reset();
      rd_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_wr(0, 64'(i), 32'(i));
         step();
      end
      wr_valid = '0;
      repeat (4) step();
      chk("stat_three", 128'(stat_delivered), 128'(3));
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("stat_after_flush", 128'(stat_delivered), 128'(3));
      rd_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         set_wr(3, 64'(i), 32'(i));
         step();
      end
      wr_valid = '0;
      chk("stat_stall3", 128'(stat_stall[3]), 128'(1));
`endif

      // Randomised traffic with occasional flush and reset.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         wr_valid = NUM_CH'($urandom);
         for (int c = 0; c < NUM_CH; c++) begin
            wr_addr[c*ADDR_W +: ADDR_W] = {$urandom, $urandom};
            wr_data[c*DATA_W +: DATA_W] = $urandom;
         end
         rd_ready = (i < 1500) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
         flush    = ($urandom_range(49) == 0);
         rst      = ($urandom_range(299) == 0);
         step();
      end
      rst      = 1'b0;
      flush    = 1'b0;
      wr_valid = '0;
      rd_ready = 1'b1;
      repeat (40) step();
      chk("final_idle", 128'(rd_valid), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
